// File: rtl/sc_pkg.sv
// sc_pkg: shared types and constants for the stochastic-computing blocks.
// Holds the decoder state enum, the result-width helper and default sizes.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } sc_state_e;

  localparam int SC_OUT_WIDTH   = 32;
  localparam int SC_FRAME_WORDS = 4;

  // Default frame length N; also the offset for bipolar results.
  localparam int SC_BIP_N = SC_OUT_WIDTH * SC_FRAME_WORDS;

  function automatic int sc_cnt_width(input int w, input int fw);
    return $clog2(w * fw + 1);
  endfunction

endpackage

// File: rtl/sc_popcount.sv
// sc_popcount: combinational ones-count of a W-bit word (adder tree).
// Ports: data_i (W bits in), count_o ($clog2(W+1) bits out).
module sc_popcount
  import sc_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] count_o
);

  // Tree padded to a power of two, stored heap-style:
  // leaves at P-1..2P-2, node i sums nodes 2i+1 and 2i+2.
  localparam int P = (W <= 1) ? 1 : (1 << $clog2(W));

  logic [CW-1:0] node [2*P-1];

  always_comb begin
    for (int i = 0; i < W; i++) begin
      node[P-1+i] = CW'(data_i[i]);
    end
    for (int i = W; i < P; i++) begin
      node[P-1+i] = '0;
    end
    for (int i = P - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
  end

  assign count_o = node[0];

endmodule

// File: rtl/sc_bitstream_decoder.sv
// sc_bitstream_decoder: counts ones over a frame of FRAME_WORDS stochastic
// words and presents the count on a valid/ready output.
// Ports: clk, rst (sync, active-high), clear (frame abort),
//   in_valid/in_ready/in_data (word input, bit 0 earliest),
//   out_valid/out_ready, res_count (0..N), res_scaled (count*2^SW/N, sat).
// Optional macro SC_DEC_BIPOLAR_EN adds input bipolar and output res_signed.
module sc_bitstream_decoder
  import sc_pkg::*;
#(
  parameter int OUT_WIDTH        = SC_OUT_WIDTH,
  parameter int FRAME_WORDS      = SC_FRAME_WORDS,
  parameter int CNT_WIDTH        = sc_cnt_width(OUT_WIDTH, FRAME_WORDS),
  parameter int sobolValidBitwth = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [OUT_WIDTH-1:0]        in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CNT_WIDTH-1:0]        res_count,
  output logic [sobolValidBitwth-1:0] res_scaled
`ifdef SC_DEC_BIPOLAR_EN
  ,
  input  logic                        bipolar,
  output logic signed [CNT_WIDTH:0]   res_signed
`endif
);

  localparam int  N      = OUT_WIDTH * FRAME_WORDS;
  localparam int  PCW    = $clog2(OUT_WIDTH + 1);
  localparam int  WCW    = $clog2(FRAME_WORDS + 1);
  localparam int  SW     = sobolValidBitwth;
  localparam int  XW     = CNT_WIDTH + SW;
  localparam bit  N_POW2 = (N & (N - 1)) == 0;
  localparam int  LOG2N  = $clog2(N);

  sc_state_e            state_q;
  logic [CNT_WIDTH-1:0] acc_q;
  logic [WCW-1:0]       wcnt_q;
  logic                 out_valid_q;
  logic [CNT_WIDTH-1:0] res_count_q;
  logic [SW-1:0]        res_scaled_q;

  logic [PCW-1:0]       pc;
  logic [CNT_WIDTH-1:0] pc_ext;
  logic                 accept;
  logic                 first_word;
  logic                 frame_done;
  logic [CNT_WIDTH-1:0] frame_sum;

  sc_popcount #(
    .W (OUT_WIDTH),
    .CW(PCW)
  ) u_popcount (
    .data_i (in_data),
    .count_o(pc)
  );

  // count*2^SW/N truncated; a full frame would give 2^SW, so saturate.
  function automatic logic [SW-1:0] scale(input logic [CNT_WIDTH-1:0] c);
    logic [XW-1:0] x;
    x = {c, {SW{1'b0}}};
    if (c == CNT_WIDTH'(N)) return {SW{1'b1}};
    if (N_POW2) return SW'(x >> LOG2N);
    return SW'(x / XW'(N));
  endfunction

  // Holding a result only stalls input while the consumer is stalled.
  assign in_ready = !clear && ((state_q != HOLD) || out_ready);
  assign accept   = in_valid && in_ready;
  assign pc_ext   = CNT_WIDTH'(pc);

  // Outside ACCUM an accepted word always opens a fresh frame.
  assign first_word = (state_q != ACCUM);
  assign frame_sum  = first_word ? pc_ext : acc_q + pc_ext;
  assign frame_done = accept &&
    (first_word ? (FRAME_WORDS == 1) : (wcnt_q == WCW'(FRAME_WORDS - 1)));

`ifdef SC_DEC_BIPOLAR_EN
  logic                 bip_q;
  logic                 frame_bip;
  logic [CNT_WIDTH:0]   res_signed_q;

  assign frame_bip = first_word ? bipolar : bip_q;

  // Modular arithmetic: 2c-N always fits the signed CNT_WIDTH+1 range.
  function automatic logic [CNT_WIDTH:0] to_signed(
    input logic [CNT_WIDTH-1:0] c,
    input logic                 b
  );
    if (b) return {c, 1'b0} - (CNT_WIDTH+1)'(N);
    return {1'b0, c};
  endfunction

  assign res_signed = $signed(res_signed_q);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      wcnt_q       <= '0;
      out_valid_q  <= 1'b0;
      res_count_q  <= '0;
      res_scaled_q <= '0;
`ifdef SC_DEC_BIPOLAR_EN
      bip_q        <= 1'b0;
      res_signed_q <= '0;
`endif
    end else if (clear) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      wcnt_q      <= '0;
      out_valid_q <= 1'b0;
    end else if (frame_done) begin
      state_q      <= HOLD;
      acc_q        <= '0;
      wcnt_q       <= '0;
      out_valid_q  <= 1'b1;
      res_count_q  <= frame_sum;
      res_scaled_q <= scale(frame_sum);
`ifdef SC_DEC_BIPOLAR_EN
      bip_q        <= frame_bip;
      res_signed_q <= to_signed(frame_sum, frame_bip);
`endif
    end else if (accept) begin
      state_q     <= ACCUM;
      acc_q       <= frame_sum;
      wcnt_q      <= first_word ? WCW'(1) : wcnt_q + 1'b1;
      out_valid_q <= 1'b0;
`ifdef SC_DEC_BIPOLAR_EN
      bip_q       <= frame_bip;
`endif
    end else if (state_q == HOLD && out_ready) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign res_count  = res_count_q;
  assign res_scaled = res_scaled_q;

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// tb_sc_bitstream_decoder: directed self-checking bench for the decoder.
// A frame-level queue model is compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_sc_bitstream_decoder;

  localparam int FW = 4;
  localparam int N  = 128;
  localparam int SW = 6;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        clear     = 1'b0;
  logic        in_valid  = 1'b0;
  logic [31:0] in_data   = '0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  res_count;
  logic [5:0]  res_scaled;
`ifdef SC_DEC_BIPOLAR_EN
  logic              bipolar = 1'b0;
  logic signed [8:0] res_signed;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sc_bitstream_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_count (res_count),
    .res_scaled(res_scaled)
`ifdef SC_DEC_BIPOLAR_EN
    ,
    .bipolar   (bipolar),
    .res_signed(res_signed)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model: collect accepted words, count ones when full.
  logic [31:0] fq [$];
  bit          m_valid = 0;
  int          m_count = 0;
  int          m_scaled = 0;
  int          m_signed = 0;
  bit          m_bip = 0;
  bit          started = 0;
  bit          m_acc;
  int          t;

  function automatic bit m_in_ready();
    return !clear && (!m_valid || out_ready);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      m_valid  = 0;
      m_count  = 0;
      m_scaled = 0;
      m_signed = 0;
      started  = 1;
    end else if (clear) begin
      fq.delete();
      m_valid = 0;
    end else begin
      m_acc = in_valid && m_in_ready();
      if (m_valid && out_ready) m_valid = 0;
      if (m_acc) begin
`ifdef SC_DEC_BIPOLAR_EN
        if (fq.size() == 0) m_bip = bipolar;
`endif
        fq.push_back(in_data);
      end
      if (fq.size() == FW) begin
        t = 0;
        foreach (fq[i]) t += $countones(fq[i]);
        m_count  = t;
        m_scaled = (t == N) ? (1 << SW) - 1 : (t * (1 << SW)) / N;
        m_signed = m_bip ? 2 * t - N : t;
        m_valid  = 1;
        fq.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, m_in_ready());
      chk("res_count", res_count, m_count);
      chk("res_scaled", res_scaled, m_scaled);
`ifdef SC_DEC_BIPOLAR_EN
      chk("res_signed", res_signed, m_signed);
`endif
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", n < 50, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [31:0] w);
    repeat (4) send(w);
  endtask

  task automatic wait_result(input string name, input int cnt,
                             input int sc);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, n < 20, 1);
    chk({name, "_count"}, res_count, cnt);
    chk({name, "_scaled"}, res_scaled, sc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_count", res_count, 0);
    chk("rst_scaled", res_scaled, 0);
    chk("rst_ready", in_ready, 1);

    send4(32'hFFFF_FFFF);
    chk("latency_valid", out_valid, 1);
    wait_result("ones", 128, 63);

    send4(32'hAAAA_AAAA);
    wait_result("alt", 64, 32);

    send(32'h1);
    send(32'h3);
    send(32'h7);
    send(32'h0);
    wait_result("mixed", 6, 3);

    idle(1);
    out_ready = 1'b0;
    send4(32'h0000_00FF);
    wait_result("hold", 32, 16);
    repeat (5) begin
      @(negedge clk);
      chk("hold_ready", in_ready, 0);
      chk("hold_count", res_count, 32);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h0000_FFFF);
    chk("turn_valid", out_valid, 0);
    send(32'h0);
    send(32'h0);
    send(32'h0);
    wait_result("turn", 16, 8);

    idle(1);
    send(32'hFFFF_FFFF);
    send(32'hFFFF_FFFF);
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    clear    = 1'b1;
    @(negedge clk);
    chk("clear_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_valid", out_valid, 0);
    send4(32'h0000_000F);
    wait_result("after_clear", 16, 8);

    idle(1);
    out_ready = 1'b0;
    send4(32'hFFFF_FFFF);
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rsthold_valid", out_valid, 0);
    chk("rsthold_count", res_count, 0);
    chk("rsthold_scaled", res_scaled, 0);
    chk("rsthold_ready", in_ready, 1);
    out_ready = 1'b1;

    send(32'hFFFF_FFFF);
    send(32'hFFFF_FFFF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstacc_valid", out_valid, 0);
    chk("rstacc_count", res_count, 0);
    send4(32'h0000_0003);
    wait_result("after_rst", 8, 4);

`ifdef SC_DEC_BIPOLAR_EN
    idle(1);
    bipolar = 1'b1;
    send4(32'h0);
    wait_result("bip_zero", 0, 0);
    chk("bip_zero_signed", res_signed, -128);
    send4(32'hFFFF_FFFF);
    wait_result("bip_ones", 128, 63);
    chk("bip_ones_signed", res_signed, 128);
    send4(32'hAAAA_AAAA);
    wait_result("bip_alt", 64, 32);
    chk("bip_alt_signed", res_signed, 0);
    bipolar = 1'b0;
`endif

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
